// File: rtl/serializer_stream_pkg.sv
// Shared types and the length rule for serializer_stream.
// Optional feature macro: SERIALIZER_PARITY_EN (see serializer_stream.sv).
package serializer_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } ser_order_t;

    // A zero or oversized bit count means "send the whole word".
    function automatic int unsigned eff_len(input int unsigned mod, input int unsigned data_w);
        if ((mod == 32'd0) || (mod > data_w)) begin
            return data_w;
        end else begin
            return mod;
        end
    endfunction

endpackage

// File: rtl/serializer_stream_shift.sv
// Shifter, bit counter, order register and last-bit detect for serializer_stream.
// The running parity of the bits sent so far is kept here as well.
module ser_shift_unit
    import serializer_stream_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_len,
    input  ser_order_t        load_order,
    input  logic              advance,
    output logic              bit_out,
    output logic              last,
    output logic              parity
);

    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [DATA_W-1:0] shreg_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  len_r;
    ser_order_t        order_r;
    logic              par_r;

    // LSB-first words are pre-aligned so the field's lowest bit sits at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r <= {DATA_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            len_r   <= {CNT_W{1'b0}};
            order_r <= MSB_FIRST;
            par_r   <= 1'b0;
        end else if (load) begin
            shreg_r <= (load_order == LSB_FIRST) ? (load_data >> (FULL_LEN - load_len)) : load_data;
            cnt_r   <= {CNT_W{1'b0}};
            len_r   <= load_len;
            order_r <= load_order;
            par_r   <= 1'b0;
        end else if (advance) begin
            shreg_r <= (order_r == LSB_FIRST) ? {1'b0, shreg_r[DATA_W-1:1]}
                                              : {shreg_r[DATA_W-2:0], 1'b0};
            par_r   <= par_r ^ bit_out;
            if (!last) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign bit_out = (order_r == LSB_FIRST) ? shreg_r[0] : shreg_r[DATA_W-1];
    assign last    = (cnt_r == (len_r - CNT_ONE));
    assign parity  = par_r;

endmodule

// File: rtl/serializer_stream.sv
// Word-to-bitstream serializer with valid/ready on both sides and a one-word hold register.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after every word.
module serializer_stream
    import serializer_stream_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W),
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_lsb_first_i,
    input  logic              data_val_i,
    output logic              data_rdy_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    input  logic              ser_data_rdy_i,
    output logic              ser_last_o,
    output logic              busy_o
);

    ser_state_t        state_r, state_nxt_s;
    logic              hold_vld_r, hold_vld_nxt_s;
    logic [DATA_W-1:0] hold_data_r;
    logic [CNT_W-1:0]  hold_len_r;
    ser_order_t        hold_order_r;
    logic              rdy_r;
    logic              busy_r;

    logic              accept_s, xfer_s, word_done_s;
    logic              load_s, load_hold_s, hold_we_s, advance_s;
    logic [CNT_W-1:0]  in_len_s, load_len_s;
    logic [DATA_W-1:0] load_data_s;
    ser_order_t        in_order_s, load_order_s;
    logic              sh_bit_s, sh_last_s, sh_par_s;
    logic              ser_val_s;

    assign in_len_s   = CNT_W'(eff_len(32'(data_mod_i), 32'(DATA_W)));
    assign in_order_s = ser_order_t'(data_lsb_first_i);

    assign ser_val_s = (state_r != IDLE);
    assign accept_s  = data_val_i & rdy_r;
    assign xfer_s    = ser_val_s & ser_data_rdy_i;
    assign advance_s = xfer_s & (state_r == SHIFT);

    assign load_data_s  = load_hold_s ? hold_data_r  : data_i;
    assign load_len_s   = load_hold_s ? hold_len_r   : in_len_s;
    assign load_order_s = load_hold_s ? hold_order_r : in_order_s;

    // Next state, shifter load source and hold-register write.
    always_comb begin
        state_nxt_s    = state_r;
        hold_vld_nxt_s = hold_vld_r;
        load_s         = 1'b0;
        load_hold_s    = 1'b0;
        hold_we_s      = 1'b0;
        word_done_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (xfer_s && sh_last_s) begin
`ifdef SERIALIZER_PARITY_EN
                    state_nxt_s = PARITY;
`else
                    word_done_s = 1'b1;
`endif
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            PARITY: begin
                if (xfer_s) begin
                    word_done_s = 1'b1;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // A held word always wins at a word boundary; rdy is low then, so no accept can collide.
        if (word_done_s) begin
            if (hold_vld_r) begin
                load_s         = 1'b1;
                load_hold_s    = 1'b1;
                hold_vld_nxt_s = 1'b0;
                state_nxt_s    = SHIFT;
            end else if (accept_s) begin
                load_s      = 1'b1;
                state_nxt_s = SHIFT;
            end else begin
                state_nxt_s = IDLE;
            end
        end else if ((state_r != IDLE) && accept_s) begin
            hold_we_s      = 1'b1;
            hold_vld_nxt_s = 1'b1;
        end else begin
            hold_we_s = 1'b0;
        end
    end

    // State, hold register and the registered handshake/status outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_r      <= IDLE;
            hold_vld_r   <= 1'b0;
            hold_data_r  <= {DATA_W{1'b0}};
            hold_len_r   <= {CNT_W{1'b0}};
            hold_order_r <= MSB_FIRST;
            rdy_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            hold_vld_r <= hold_vld_nxt_s;
            rdy_r      <= !hold_vld_nxt_s;
            busy_r     <= (state_nxt_s != IDLE) | hold_vld_nxt_s;
            if (hold_we_s) begin
                hold_data_r  <= data_i;
                hold_len_r   <= in_len_s;
                hold_order_r <= in_order_s;
            end
        end
    end

    ser_shift_unit #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_shift (
        .clk        (clk_i),
        .rst        (arst_i),
        .load       (load_s),
        .load_data  (load_data_s),
        .load_len   (load_len_s),
        .load_order (load_order_s),
        .advance    (advance_s),
        .bit_out    (sh_bit_s),
        .last       (sh_last_s),
        .parity     (sh_par_s)
    );

    assign ser_data_val_o = ser_val_s;
    assign data_rdy_o     = rdy_r;
    assign busy_o         = busy_r;
    assign ser_data_o     = (state_r == PARITY) ? sh_par_s : ((state_r == SHIFT) & sh_bit_s);
`ifdef SERIALIZER_PARITY_EN
    assign ser_last_o = (state_r == PARITY);
`else
    assign ser_last_o = (state_r == SHIFT) & sh_last_s;
`endif

endmodule
